fan_level_controller: RTL and testbench



---
 rtl/fan_level_controller_pkg.sv | 26 ++
 rtl/fan_level_controller_btn_edge_detect.sv | 19 +
 rtl/fan_level_controller.sv | 178 +++++++++++++++++
 tb/tb_fan_level_controller.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fan_level_controller_pkg.sv
// Shared state encodings, button bundle and helpers for the fan level controller.
package fan_level_controller_pkg;

  localparam int unsigned FLC_STATE_WIDTH = 3;

  localparam logic [FLC_STATE_WIDTH-1:0] FLC_STANDBY  = 3'd0;
  localparam logic [FLC_STATE_WIDTH-1:0] FLC_ARMED    = 3'd1;
  localparam logic [FLC_STATE_WIDTH-1:0] FLC_RUN      = 3'd2;
  localparam logic [FLC_STATE_WIDTH-1:0] FLC_TURBO    = 3'd3;
  localparam logic [FLC_STATE_WIDTH-1:0] FLC_COOLDOWN = 3'd4;

  typedef struct packed {
    logic stop;
    logic down;
    logic up;
    logic menu;
  } flc_btn_t;

  function automatic int unsigned flc_max3(input int unsigned a, input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fan_level_controller_btn_edge_detect.sv
// Rising-edge detector for one debounced button; prev resets high so a
// button held through reset never produces an edge.
module btn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_edge_c
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= i_btn;
  end

  assign o_edge_c = i_btn & ~r_prev;

endmodule

// File: rtl/fan_level_controller.sv
// Hood fan level controller: menu arming, levels 1..NUM_LEVELS-1, one
// time-limited turbo per power session and a timed cooldown before standby.
module fan_level_controller
  import fan_level_controller_pkg::*;
#(
  parameter int unsigned NUM_LEVELS      = 3,
  parameter int unsigned ARM_WINDOW      = 500,
  parameter int unsigned TURBO_CYCLES    = 6000,
  parameter int unsigned COOLDOWN_CYCLES = 3000,
  parameter int unsigned LW              = $clog2(NUM_LEVELS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          power_on,
  input  logic          menu_btn,
  input  logic          up_btn,
  input  logic          down_btn,
  input  logic          stop_btn,
  output logic [LW-1:0] level_o,
  output logic          level_change_o,
  output logic          armed_o,
  output logic          cooldown_o,
  output logic          turbo_used_o
);

  localparam int unsigned TMAX = flc_max3(ARM_WINDOW, TURBO_CYCLES, COOLDOWN_CYCLES);
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [LW-1:0] LVL_ZERO = '0;
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_PRE  = LW'(NUM_LEVELS - 1);
  localparam logic [LW-1:0] LVL_TOP  = LW'(NUM_LEVELS);

  localparam logic [TW-1:0] T_ARM  = TW'(ARM_WINDOW - 1);
  localparam logic [TW-1:0] T_TURB = TW'(TURBO_CYCLES - 1);
  localparam logic [TW-1:0] T_COOL = TW'(COOLDOWN_CYCLES - 1);

  flc_btn_t w_edge;

  btn_edge_detect u_edge_menu (.clk(clk), .rst(rst), .i_btn(menu_btn), .o_edge_c(w_edge.menu));
  btn_edge_detect u_edge_up   (.clk(clk), .rst(rst), .i_btn(up_btn),   .o_edge_c(w_edge.up));
  btn_edge_detect u_edge_down (.clk(clk), .rst(rst), .i_btn(down_btn), .o_edge_c(w_edge.down));
  btn_edge_detect u_edge_stop (.clk(clk), .rst(rst), .i_btn(stop_btn), .o_edge_c(w_edge.stop));

  logic [FLC_STATE_WIDTH-1:0] r_state;
  logic [FLC_STATE_WIDTH-1:0] w_state_nxt;
  logic [LW-1:0]              r_level;
  logic [LW-1:0]              w_level_nxt;
  logic [TW-1:0]              r_timer;
  logic [TW-1:0]              w_timer_nxt;
  logic                       r_turbo_used;
  logic                       w_turbo_used_nxt;
  logic                       r_level_change;
  logic                       r_armed;
  logic                       r_cooldown;
  logic                       w_timer_zero;

  assign w_timer_zero = (r_timer == '0);

  // Within each state, edges are tested stop > down > up > menu; an acted
  // edge always beats timer expiry in the same cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_level_nxt      = r_level;
    w_timer_nxt      = r_timer;
    w_turbo_used_nxt = r_turbo_used;
    if (!power_on) begin
      w_state_nxt      = FLC_STANDBY;
      w_level_nxt      = LVL_ZERO;
      w_timer_nxt      = '0;
      w_turbo_used_nxt = 1'b0;
    end else begin
      case (r_state)
        FLC_STANDBY: begin
          if (w_edge.menu) begin
            w_state_nxt = FLC_ARMED;
            w_timer_nxt = T_ARM;
          end
        end
        FLC_ARMED: begin
          if (w_edge.stop) begin
            w_state_nxt = FLC_STANDBY;
            w_timer_nxt = '0;
          end else if (w_edge.up) begin
            w_state_nxt = FLC_RUN;
            w_level_nxt = LVL_ONE;
            w_timer_nxt = '0;
          end else if (w_edge.menu || w_timer_zero) begin
            w_state_nxt = FLC_STANDBY;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
        FLC_RUN: begin
          if (w_edge.stop) begin
            w_state_nxt = FLC_COOLDOWN;
            w_level_nxt = LVL_ONE;
            w_timer_nxt = T_COOL;
          end else if (w_edge.down) begin
            if (r_level > LVL_ONE) begin
              w_level_nxt = r_level - LW'(1);
            end else begin
              w_state_nxt = FLC_STANDBY;
              w_level_nxt = LVL_ZERO;
            end
          end else if (w_edge.up) begin
            if (r_level < LVL_PRE) begin
              w_level_nxt = r_level + LW'(1);
            end else if (!r_turbo_used) begin
              w_state_nxt      = FLC_TURBO;
              w_level_nxt      = LVL_TOP;
              w_turbo_used_nxt = 1'b1;
              w_timer_nxt      = T_TURB;
            end
          end
        end
        FLC_TURBO: begin
          if (w_edge.stop) begin
            w_state_nxt = FLC_COOLDOWN;
            w_level_nxt = LVL_ONE;
            w_timer_nxt = T_COOL;
          end else if (w_edge.down || w_timer_zero) begin
            w_state_nxt = FLC_RUN;
            w_level_nxt = LVL_PRE;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
        FLC_COOLDOWN: begin
          if (w_edge.up) begin
            w_state_nxt = FLC_RUN;
            w_level_nxt = LVL_ONE;
            w_timer_nxt = '0;
          end else if (w_timer_zero) begin
            w_state_nxt = FLC_STANDBY;
            w_level_nxt = LVL_ZERO;
          end else begin
            w_timer_nxt = r_timer - TW'(1);
          end
        end
        default: begin
          w_state_nxt = FLC_STANDBY;
          w_level_nxt = LVL_ZERO;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= FLC_STANDBY;
      r_level        <= LVL_ZERO;
      r_timer        <= '0;
      r_turbo_used   <= 1'b0;
      r_level_change <= 1'b0;
      r_armed        <= 1'b0;
      r_cooldown     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_level        <= w_level_nxt;
      r_timer        <= w_timer_nxt;
      r_turbo_used   <= w_turbo_used_nxt;
      r_level_change <= (w_level_nxt != r_level);
      r_armed        <= (w_state_nxt == FLC_ARMED);
      r_cooldown     <= (w_state_nxt == FLC_COOLDOWN);
    end
  end

  assign level_o        = r_level;
  assign level_change_o = r_level_change;
  assign armed_o        = r_armed;
  assign cooldown_o     = r_cooldown;
  assign turbo_used_o   = r_turbo_used;

endmodule

// File: tb/tb_fan_level_controller.sv
// Directed, table-driven bench for fan_level_controller (3 levels, short timers).
module tb_fan_level_controller;

  localparam int unsigned NL = 3;
  localparam int unsigned AW = 4;
  localparam int unsigned TC = 8;
  localparam int unsigned CC = 5;
  localparam int unsigned LW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          power_on;
  logic          menu_btn;
  logic          up_btn;
  logic          down_btn;
  logic          stop_btn;
  logic [LW-1:0] level_o;
  logic          level_change_o;
  logic          armed_o;
  logic          cooldown_o;
  logic          turbo_used_o;

  fan_level_controller #(
    .NUM_LEVELS(NL), .ARM_WINDOW(AW), .TURBO_CYCLES(TC), .COOLDOWN_CYCLES(CC), .LW(LW)
  ) dut (
    .clk(clk), .rst(rst), .power_on(power_on),
    .menu_btn(menu_btn), .up_btn(up_btn), .down_btn(down_btn), .stop_btn(stop_btn),
    .level_o(level_o), .level_change_o(level_change_o), .armed_o(armed_o),
    .cooldown_o(cooldown_o), .turbo_used_o(turbo_used_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          p, m, u, d, s;
    logic [LW-1:0] lvl;
    logic          ch, arm, cd, tu;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input logic p, m, u, d, s, input int lvl,
                              input logic ch, arm, cd, tu);
    vec_t v;
    v.p = p; v.m = m; v.u = u; v.d = d; v.s = s;
    v.lvl = LW'(lvl);
    v.ch = ch; v.arm = arm; v.cd = cd; v.tu = tu;
    return v;
  endfunction

  function automatic void add(input logic p, m, u, d, s, input int lvl,
                              input logic ch, arm, cd, tu);
    vecs.push_back(mk(p, m, u, d, s, lvl, ch, arm, cd, tu));
  endfunction

  task automatic check(input string name, input vec_t v);
    logic [LW+3:0] act;
    logic [LW+3:0] exp;
    act = {level_o, level_change_o, armed_o, cooldown_o, turbo_used_o};
    exp = {v.lvl, v.ch, v.arm, v.cd, v.tu};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got lvl=%0d chg=%b arm=%b cd=%b tu=%b, expected lvl=%0d chg=%b arm=%b cd=%b tu=%b",
               name, level_o, level_change_o, armed_o, cooldown_o, turbo_used_o,
               v.lvl, v.ch, v.arm, v.cd, v.tu);
    end
  endtask

  // One cycle: drive inputs, let the edge sample them, then compare.
  task automatic apply(input vec_t v, input string name);
    power_on = v.p; menu_btn = v.m; up_btn = v.u; down_btn = v.d; stop_btn = v.s;
    @(posedge clk);
    #1;
    check(name, v);
  endtask

  initial begin
    // p m u d s | lvl ch arm cd tu
    add(1,0,0,0,0, 0,0,0,0,0);                               // idle after reset
    add(1,1,0,0,0, 0,0,1,0,0);                               // arm
    add(1,0,0,0,0, 0,0,1,0,0);
    add(1,0,1,0,0, 1,1,0,0,0);                               // up -> level 1
    add(1,0,0,0,0, 1,0,0,0,0);
    add(1,0,0,0,1, 1,0,0,1,0);                               // stop at 1: no pulse
    for (int i = 0; i < 4; i++) add(1,0,0,0,0, 1,0,0,1,0);
    add(1,0,0,0,0, 0,1,0,0,0);                               // cooldown done
    add(1,1,0,0,0, 0,0,1,0,0);                               // arm, then time out
    for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0,0,1,0,0);
    add(1,0,0,0,0, 0,0,0,0,0);
    add(1,0,1,1,1, 0,0,0,0,0);                               // ignored in standby
    add(1,0,0,0,0, 0,0,0,0,0);
    add(1,1,0,0,0, 0,0,1,0,0);
    add(1,0,1,0,0, 1,1,0,0,0);
    add(1,0,0,0,0, 1,0,0,0,0);
    add(1,0,1,0,0, 2,1,0,0,0);
    add(1,0,0,0,0, 2,0,0,0,0);
    add(1,0,1,0,0, 3,1,0,0,1);                               // turbo
    for (int i = 0; i < 7; i++) add(1,0,0,0,0, 3,0,0,0,1);
    add(1,0,0,0,0, 2,1,0,0,1);                               // turbo expired
    add(1,0,1,0,0, 2,0,0,0,1);                               // turbo already used
    add(1,0,0,0,0, 2,0,0,0,1);
    add(1,0,1,0,1, 1,1,0,1,1);                               // stop beats up
    add(1,0,0,0,0, 1,0,0,1,1);
    add(1,0,0,0,0, 1,0,0,1,1);
    add(1,0,1,0,0, 1,0,0,0,1);                               // resume from cooldown
    add(1,0,0,0,0, 1,0,0,0,1);
    add(1,0,1,0,0, 2,1,0,0,1);
    add(1,0,0,0,0, 2,0,0,0,1);
    add(1,0,1,1,0, 1,1,0,0,1);                               // down beats up
    add(1,0,0,0,0, 1,0,0,0,1);
    add(1,0,0,1,0, 0,1,0,0,1);                               // down at 1: standby
    add(0,0,0,0,0, 0,0,0,0,0);                               // session ends
    add(1,1,0,0,0, 0,0,1,0,0);
    add(1,0,1,0,0, 1,1,0,0,0);
    add(1,0,0,0,0, 1,0,0,0,0);
    add(1,0,1,0,0, 2,1,0,0,0);
    add(1,0,0,0,0, 2,0,0,0,0);
    add(1,0,1,0,0, 3,1,0,0,1);                               // turbo in new session
    add(1,0,0,0,0, 3,0,0,0,1);
    add(1,0,0,1,0, 2,1,0,0,1);                               // down leaves turbo
    add(1,0,0,0,0, 2,0,0,0,1);
    add(0,1,0,0,0, 0,1,0,0,0);                               // power off beats menu
    add(1,1,0,0,0, 0,0,0,0,0);                               // held menu: no edge
    add(1,0,0,0,0, 0,0,0,0,0);
    add(1,1,0,0,0, 0,0,1,0,0);
    add(1,0,1,0,0, 1,1,0,0,0);
    add(1,0,0,0,0, 1,0,0,0,0);
    add(1,0,1,0,0, 2,1,0,0,0);
    add(1,0,0,0,0, 2,0,0,0,0);
    add(1,0,1,0,0, 3,1,0,0,1);
    add(1,0,0,0,0, 3,0,0,0,1);
    add(0,0,0,0,0, 0,1,0,0,0);                               // power off mid-turbo
    add(1,0,0,0,0, 0,0,0,0,0);

    rst = 1'b1; power_on = 1'b1;
    menu_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0; stop_btn = 1'b0;
    @(posedge clk);
    #1;
    check("reset", mk(1,0,0,0,0, 0,0,0,0,0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Turbo then stop, then reset mid-cooldown.
    apply(mk(1,1,0,0,0, 0,0,1,0,0), "h_arm");
    apply(mk(1,0,1,0,0, 1,1,0,0,0), "h_lvl1");
    apply(mk(1,0,0,0,0, 1,0,0,0,0), "h_idle1");
    apply(mk(1,0,1,0,0, 2,1,0,0,0), "h_lvl2");
    apply(mk(1,0,0,0,0, 2,0,0,0,0), "h_idle2");
    apply(mk(1,0,1,0,0, 3,1,0,0,1), "h_turbo");
    apply(mk(1,0,0,0,1, 1,1,0,1,1), "h_turbo_stop");
    apply(mk(1,0,0,0,0, 1,0,0,1,1), "h_cooldown");
    rst = 1'b1;
    apply(mk(1,0,0,0,0, 0,0,0,0,0), "h_rst_mid_cooldown");
    apply(mk(1,1,0,0,0, 0,0,0,0,0), "h_rst_menu_held");
    rst = 1'b0;
    apply(mk(1,1,0,0,0, 0,0,0,0,0), "h_held_through_reset");
    apply(mk(1,0,0,0,0, 0,0,0,0,0), "h_release");
    apply(mk(1,1,0,0,0, 0,0,1,0,0), "h_rearm");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
